// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - 4-bit Johnson code decoder with sequence lock FSM and error/wrap counters
module johnson_decoder #(
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  input  logic [3:0]       in_code,
  input  logic             clr_err,
  output logic [2:0]       dec_val,
  output logic             dec_vld,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);

  state_t     state, state_nx;
  logic [3:0] ref_code, ref_nx;
  logic [3:0] run, run_nx, run_inc;
  logic       in_legal;
  logic [2:0] in_idx, ref_idx, succ_idx;
  logic       is_succ;
  logic       code_err_nx, seq_err_nx, wrap_inc;

  always_comb begin
    in_legal = 1'b1;
    in_idx   = 3'd0;
    case (in_code)
      4'b0000: in_idx = 3'd0;
      4'b1000: in_idx = 3'd1;
      4'b1100: in_idx = 3'd2;
      4'b1110: in_idx = 3'd3;
      4'b1111: in_idx = 3'd4;
      4'b0111: in_idx = 3'd5;
      4'b0011: in_idx = 3'd6;
      4'b0001: in_idx = 3'd7;
      default: in_legal = 1'b0;
    endcase
  end

  // ref_code only ever holds legal codes, so no legality flag is needed here
  always_comb begin
    ref_idx = 3'd0;
    case (ref_code)
      4'b1000: ref_idx = 3'd1;
      4'b1100: ref_idx = 3'd2;
      4'b1110: ref_idx = 3'd3;
      4'b1111: ref_idx = 3'd4;
      4'b0111: ref_idx = 3'd5;
      4'b0011: ref_idx = 3'd6;
      4'b0001: ref_idx = 3'd7;
      default: ref_idx = 3'd0;
    endcase
  end

  assign succ_idx = ref_idx + 3'd1;
  assign is_succ  = (in_idx == succ_idx);
  assign run_inc  = run + 4'd1;

  always_comb begin
    state_nx    = state;
    ref_nx      = ref_code;
    run_nx      = run;
    code_err_nx = 1'b0;
    seq_err_nx  = 1'b0;
    wrap_inc    = 1'b0;
    if (in_valid) begin
      if (!in_legal) begin
        code_err_nx = 1'b1;
        state_nx    = UNLOCK;
        run_nx      = 4'd0;
      end else begin
        ref_nx = in_code;
        case (state)
          UNLOCK: begin
            state_nx = ACQ;
            run_nx   = 4'd0;
          end
          ACQ: begin
            if (is_succ) begin
              run_nx = run_inc;
              if (run_inc == LOCK_CNT_L) begin
                state_nx = LOCKED;
                wrap_inc = (ref_idx == 3'd7);
              end
            end else begin
              run_nx = 4'd0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              wrap_inc = (ref_idx == 3'd7);
            end else begin
              seq_err_nx = 1'b1;
              state_nx   = ACQ;
              run_nx     = 4'd0;
            end
          end
          default: begin
            state_nx = UNLOCK;
            run_nx   = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= UNLOCK;
      ref_code <= 4'b0000;
      run      <= 4'd0;
      dec_val  <= 3'd0;
      dec_vld  <= 1'b0;
      code_err <= 1'b0;
      seq_err  <= 1'b0;
      locked   <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      state    <= state_nx;
      ref_code <= ref_nx;
      run      <= run_nx;
      dec_vld  <= in_valid && in_legal;
      code_err <= code_err_nx;
      seq_err  <= seq_err_nx;
      locked   <= (state_nx == LOCKED);
      if (in_valid && in_legal) begin
        dec_val <= in_idx;
      end
      if (clr_err) begin
        err_cnt <= '0;
      end else if ((code_err_nx || seq_err_nx) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (wrap_inc) begin
        wrap_cnt <= wrap_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - self-checking bench for johnson_decoder
module tb_johnson_decoder;

  localparam int LC = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid;
  logic [3:0] in_code;
  logic       clr_err;
  logic [2:0] dec_val;
  logic       dec_vld, code_err, seq_err, locked;
  logic [7:0] err_cnt, wrap_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  johnson_decoder #(.LOCK_CNT(LC), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_code(in_code),
    .clr_err(clr_err), .dec_val(dec_val), .dec_vld(dec_vld),
    .code_err(code_err), .seq_err(seq_err), .locked(locked),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic       clr;
    logic [2:0] dv;
    logic       vld, ce, se, lk;
    logic [7:0] ec, wc;
  } vec_t;

  vec_t vecs[21];

  logic [3:0] codes[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] dv, input logic vld,
                           input logic ce, input logic se, input logic lk,
                           input logic [7:0] ec, input logic [7:0] wc);
    chk({tag, ".dec_val"}, 32'(dec_val), 32'(dv));
    chk({tag, ".dec_vld"}, 32'(dec_vld), 32'(vld));
    chk({tag, ".code_err"}, 32'(code_err), 32'(ce));
    chk({tag, ".seq_err"}, 32'(seq_err), 32'(se));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    chk({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(wc));
  endtask

  task automatic apply(input logic v, input logic [3:0] c, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_code  = c;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst    = 1'b0;
    in_valid = 1'b0;
    in_code  = 4'b0000;
    clr_err  = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  function automatic int code_idx(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  // reference model: lock is "at least LC successor steps in an unbroken chain"
  int         m_have, m_last, m_chain;
  logic [2:0] m_dv;
  logic       m_vld, m_ce, m_se;
  logic [7:0] m_ec, m_wc;

  task automatic model_step(input logic v, input logic [3:0] c, input logic clr);
    int k;
    logic ev;
    m_vld = 1'b0; m_ce = 1'b0; m_se = 1'b0; ev = 1'b0;
    if (v) begin
      k = code_idx(c);
      if (k < 0) begin
        m_ce = 1'b1; ev = 1'b1;
        m_have = 0; m_chain = 0;
      end else begin
        m_vld = 1'b1;
        m_dv  = 3'(k);
        if (m_have != 0 && k == (m_last + 1) % 8) begin
          if (m_chain < 1000) m_chain++;
          if (m_chain >= LC && m_last == 7) m_wc = m_wc + 8'd1;
        end else begin
          if (m_have != 0 && m_chain >= LC) begin
            m_se = 1'b1; ev = 1'b1;
          end
          m_chain = 0;
        end
        m_have = 1;
        m_last = k;
      end
    end
    if (clr) m_ec = 8'd0;
    else if (ev && m_ec != 8'hff) m_ec = m_ec + 8'd1;
  endtask

  task automatic model_reset();
    m_have = 0; m_last = 0; m_chain = 0;
    m_dv = 3'd0; m_vld = 1'b0; m_ce = 1'b0; m_se = 1'b0;
    m_ec = 8'd0; m_wc = 8'd0;
  endtask

  initial begin
    logic [3:0] c;
    logic       v, clr;
    int         r;

    codes[0] = 4'b0000; codes[1] = 4'b1000; codes[2] = 4'b1100; codes[3] = 4'b1110;
    codes[4] = 4'b1111; codes[5] = 4'b0111; codes[6] = 4'b0011; codes[7] = 4'b0001;

    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{1'b1, 4'b1000, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{1'b1, 4'b1100, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{1'b1, 4'b1110, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[4]  = '{1'b1, 4'b1111, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[5]  = '{1'b1, 4'b0111, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[6]  = '{1'b1, 4'b0011, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[7]  = '{1'b1, 4'b0001, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[8]  = '{1'b1, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1};
    vecs[9]  = '{1'b1, 4'b1000, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1};
    vecs[10] = '{1'b1, 4'b1100, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1};
    vecs[11] = '{1'b1, 4'b0111, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1};
    vecs[12] = '{1'b1, 4'b0011, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
    vecs[13] = '{1'b1, 4'b0001, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
    vecs[14] = '{1'b1, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
    vecs[15] = '{1'b1, 4'b1000, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1};
    vecs[16] = '{1'b0, 4'b1010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1};
    vecs[17] = '{1'b1, 4'b1100, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1};
    vecs[18] = '{1'b1, 4'b1010, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1};
    vecs[19] = '{1'b1, 4'b1010, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1};
    vecs[20] = '{1'b0, 4'b0000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};

    n_rst = 1'b0; in_valid = 1'b0; in_code = 4'b0000; clr_err = 1'b0;
    #12;
    check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].v, vecs[i].code, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].dv, vecs[i].vld, vecs[i].ce,
                vecs[i].se, vecs[i].lk, vecs[i].ec, vecs[i].wc);
    end

    // error counter saturation and clear-over-increment priority
    do_reset();
    for (int i = 0; i < 300; i++) apply(1'b1, 4'b0101, 1'b0);
    chk("sat.err_cnt", 32'(err_cnt), 32'd255);
    chk("sat.code_err", 32'(code_err), 32'd1);
    apply(1'b1, 4'b1001, 1'b1);
    chk("clr_with_err.err_cnt", 32'(err_cnt), 32'd0);

    // asynchronous reset mid-lock, then a fresh lock run is required
    do_reset();
    for (int i = 0; i < 6; i++) apply(1'b1, codes[i], 1'b0);
    chk("pre_rst.locked", 32'(locked), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1 check_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    #1 n_rst = 1'b1;
    for (int i = 6; i < 10; i++) apply(1'b1, codes[i % 8], 1'b0);
    chk("relock_short.locked", 32'(locked), 32'd0);
    apply(1'b1, codes[2], 1'b0);
    chk("relock.locked", 32'(locked), 32'd1);
    chk("relock.wrap_cnt", 32'(wrap_cnt), 32'd0);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      r   = $urandom_range(0, 99);
      if (r < 75 && m_have != 0) c = codes[(m_last + 1) % 8];
      else if (r < 92) c = codes[$urandom_range(0, 7)];
      else c = 4'($urandom_range(0, 15));
      apply(v, c, clr);
      model_step(v, c, clr);
      check_all($sformatf("rnd%0d", n), m_dv, m_vld, m_ce, m_se,
                1'(m_chain >= LC), m_ec, m_wc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
